// File: rtl/mux2_burst_arbiter.sv
// Round-robin burst arbiter that shares one MUX2 output channel between two
// valid/ready sources.
//
// A source owns the channel from arbitration until its last beat is accepted.
// A MAX_BURST watchdog also releases the channel when the beat count reaches
// its limit.
//
// The registered select drives the S input of the per-bit MUX2 datapath.
module mux2_burst_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              sel,
  output logic              busy,
  output logic              burst_err
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t           state_reg, state_next;
  logic             sel_reg, sel_next;
  logic             prio_reg, prio_next;
  logic             burst_err_reg, burst_err_next;
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic             owner_last;
  logic             at_cap;

  // State register: the burst is abandoned on reset, and the tie priority returns to s0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_reg       <= 1'b0;
      prio_reg      <= 1'b0;
      burst_err_reg <= 1'b0;
      beat_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      prio_reg      <= prio_next;
      burst_err_reg <= burst_err_next;
      beat_cnt_reg  <= beat_cnt_next;
    end
  end

  // Arbitration, handshake pass-through for the owner, and burst termination.
  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    prio_next      = prio_reg;
    beat_cnt_next  = beat_cnt_reg;
    burst_err_next = 1'b0;
    m_valid        = 1'b0;
    m_last         = 1'b0;
    s0_ready       = 1'b0;
    s1_ready       = 1'b0;
    owner_last     = 1'b0;
    at_cap         = (beat_cnt_reg == CNT_LAST);

    case (state_reg)
      IDLE: begin
        beat_cnt_next = '0;
        // The prio bit only matters when both sources request together.
        if (s0_valid && (!s1_valid || !prio_reg)) begin
          state_next = BUSY0;
          sel_next   = 1'b0;
        end else if (s1_valid) begin
          state_next = BUSY1;
          sel_next   = 1'b1;
        end
      end
      BUSY0: begin
        m_valid    = s0_valid;
        s0_ready   = m_ready;
        owner_last = s0_last;
      end
      BUSY1: begin
        m_valid    = s1_valid;
        s1_ready   = m_ready;
        owner_last = s1_last;
      end
      default: state_next = IDLE;
    endcase

    if (state_reg != IDLE) begin
      m_last = m_valid & (owner_last | at_cap);
      if (m_valid && m_ready) begin
        if (m_last) begin
          // The loser of this turn wins the next tie.
          state_next     = IDLE;
          prio_next      = (state_reg == BUSY0);
          beat_cnt_next  = '0;
          burst_err_next = ~owner_last;
        end else begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
    end

    // No beat may be accepted or presented while reset is asserted.
    if (rst) begin
      m_valid  = 1'b0;
      m_last   = 1'b0;
      s0_ready = 1'b0;
      s1_ready = 1'b0;
    end
  end

  // Per-bit MUX2 datapath steered by the registered select.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_mux
      assign m_data[gi] = sel_reg ? s1_data[gi] : s0_data[gi];
    end
  endgenerate

  assign sel       = sel_reg;
  assign busy      = (state_reg != IDLE);
  assign burst_err = burst_err_reg;

endmodule

// File: tb/tb_mux2_burst_arbiter.sv
// Directed testbench for mux2_burst_arbiter (DATA_W=8, MAX_BURST=16).
// Inputs change 1 time unit after a rising edge. Outputs are checked 1 time unit later.
module tb_mux2_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       s0_valid, s0_ready, s0_last;
  logic [7:0] s0_data;
  logic       s1_valid, s1_ready, s1_last;
  logic [7:0] s1_data;
  logic       m_valid, m_ready, m_last;
  logic [7:0] m_data;
  logic       sel, busy, burst_err;

  int vectors    = 0;
  int miscompares = 0;

  mux2_burst_arbiter #(.DATA_W(8), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_last(s0_last),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_last(s1_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sel(sel), .busy(busy), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle values for the alternating-grant test.
  logic [11:0] t3_busy = 12'hDB6;
  logic [11:0] t3_sel  = 12'hC70;
  logic [11:0] t3_last = 12'h924;
  logic [7:0]  t3_data [12] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11,
                                8'h00, 8'h02, 8'h03, 8'h00, 8'h12, 8'h13};

  int  c0, c1;
  logic acc0, acc1;

  initial begin
    // 1: reset held for two cycles with both sources requesting
    rst = 1'b1; m_ready = 1'b1;
    s0_valid = 1'b1; s0_data = 8'h5A; s0_last = 1'b0;
    s1_valid = 1'b1; s1_data = 8'hA5; s1_last = 1'b0;
    tick(); tick();
    chk("rst_s0_ready", 32'(s0_ready), 0);
    chk("rst_s1_ready", 32'(s1_ready), 0);
    chk("rst_sel",      32'(sel), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_m_valid",  32'(m_valid), 0);
    chk("rst_m_last",   32'(m_last), 0);
    chk("rst_burst_err", 32'(burst_err), 0);

    // 2: s1 alone, 3-beat burst
    rst = 1'b0; s0_valid = 1'b0;
    s1_valid = 1'b1; s1_data = 8'hA1; s1_last = 1'b0; #1;
    chk("t2_arb_m_valid", 32'(m_valid), 0);
    chk("t2_arb_s1_ready", 32'(s1_ready), 0);
    tick(); #1;
    chk("t2_sel",      32'(sel), 1);
    chk("t2_busy",     32'(busy), 1);
    chk("t2_m_valid",  32'(m_valid), 1);
    chk("t2_s1_ready", 32'(s1_ready), 1);
    chk("t2_s0_ready", 32'(s0_ready), 0);
    chk("t2_data1",    32'(m_data), 32'hA1);
    chk("t2_last1",    32'(m_last), 0);
    tick(); s1_data = 8'hA2; #1;
    chk("t2_data2", 32'(m_data), 32'hA2);
    chk("t2_last2", 32'(m_last), 0);
    tick(); s1_data = 8'hA3; s1_last = 1'b1; #1;
    chk("t2_data3", 32'(m_data), 32'hA3);
    chk("t2_last3", 32'(m_last), 1);
    tick(); s1_valid = 1'b0; s1_last = 1'b0; #1;
    chk("t2_idle_busy",  32'(busy), 0);
    chk("t2_idle_valid", 32'(m_valid), 0);
    chk("t2_idle_sel",   32'(sel), 1);
    chk("t2_no_err",     32'(burst_err), 0);

    // 3: both sources request continuously with 2-beat bursts
    rst = 1'b1; tick(); rst = 1'b0;
    c0 = 0; c1 = 0;
    for (int c = 0; c < 12; c++) begin
      s0_valid = 1'b1; s0_data = 8'(c0);       s0_last = c0[0];
      s1_valid = 1'b1; s1_data = 8'(8'h10 + c1); s1_last = c1[0];
      #1;
      chk($sformatf("t3_busy_c%0d", c), 32'(busy), 32'(t3_busy[c]));
      chk($sformatf("t3_sel_c%0d", c),  32'(sel),  32'(t3_sel[c]));
      chk($sformatf("t3_last_c%0d", c), 32'(m_last), 32'(t3_last[c]));
      if (t3_busy[c]) chk($sformatf("t3_data_c%0d", c), 32'(m_data), 32'(t3_data[c]));
      acc0 = s0_valid & s0_ready;
      acc1 = s1_valid & s1_ready;
      tick();
      if (acc0) c0++;
      if (acc1) c1++;
    end

    // 4: s0 streams 20 beats without last; the watchdog ends the burst at 16 beats
    rst = 1'b1; s1_valid = 1'b0; s0_valid = 1'b0; tick(); rst = 1'b0;
    c0 = 0;
    for (int c = 0; c < 22; c++) begin
      s0_valid = 1'b1; s0_data = 8'(c0); s0_last = 1'b0; #1;
      chk($sformatf("t4_busy_c%0d", c), 32'(busy), 32'((c >= 1 && c <= 16) || c >= 18));
      chk($sformatf("t4_last_c%0d", c), 32'(m_last), 32'(c == 16));
      chk($sformatf("t4_err_c%0d", c),  32'(burst_err), 32'(c == 17));
      if (c >= 1 && c <= 16) chk($sformatf("t4_data_c%0d", c), 32'(m_data), 32'(c - 1));
      if (c >= 18) chk($sformatf("t4_data_c%0d", c), 32'(m_data), 32'(c - 2));
      acc0 = s0_valid & s0_ready;
      tick();
      if (acc0) c0++;
    end
    chk("t4_beats_accepted", 32'(c0), 20);

    // 5: m_ready toggles during a 3-beat s0 burst
    s0_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    s0_valid = 1'b1; s0_data = 8'hD0; s0_last = 1'b0; m_ready = 1'b1; tick();
    #1;
    chk("t5_b1_ready", 32'(s0_ready), 1);
    chk("t5_b1_data",  32'(m_data), 32'hD0);
    tick(); s0_data = 8'hD1; m_ready = 1'b0; #1;
    chk("t5_stall1_ready", 32'(s0_ready), 0);
    chk("t5_stall1_valid", 32'(m_valid), 1);
    chk("t5_stall1_data",  32'(m_data), 32'hD1);
    chk("t5_stall1_cnt",   32'(dut.beat_cnt_reg), 1);
    tick(); m_ready = 1'b1; #1;
    chk("t5_b2_ready", 32'(s0_ready), 1);
    chk("t5_b2_data",  32'(m_data), 32'hD1);
    chk("t5_b2_cnt",   32'(dut.beat_cnt_reg), 1);
    tick(); s0_data = 8'hD2; s0_last = 1'b1; m_ready = 1'b0; #1;
    chk("t5_stall2_ready", 32'(s0_ready), 0);
    chk("t5_stall2_last",  32'(m_last), 1);
    chk("t5_stall2_cnt",   32'(dut.beat_cnt_reg), 2);
    tick(); m_ready = 1'b1; #1;
    chk("t5_b3_ready", 32'(s0_ready), 1);
    chk("t5_b3_busy",  32'(busy), 1);
    tick(); s0_valid = 1'b0; s0_last = 1'b0; #1;
    chk("t5_done_busy", 32'(busy), 0);
    chk("t5_done_err",  32'(burst_err), 0);

    // 6: reset arrives on beat 2 of a 4-beat s0 burst
    s0_valid = 1'b1; s0_data = 8'hE0; s0_last = 1'b0; tick();
    #1;
    chk("t6_b1_ready", 32'(s0_ready), 1);
    tick(); s0_data = 8'hE1; rst = 1'b1; #1;
    chk("t6_rst_ready", 32'(s0_ready), 0);
    chk("t6_rst_valid", 32'(m_valid), 0);
    tick(); rst = 1'b0; s0_valid = 1'b0; #1;
    chk("t6_busy",  32'(busy), 0);
    chk("t6_sel",   32'(sel), 0);
    chk("t6_cnt",   32'(dut.beat_cnt_reg), 0);
    chk("t6_valid", 32'(m_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
